// File: rtl/stall_bubble_controller.sv
// Front-of-pipeline stall/flush control: owns the FETCH->DECODE register, gates the PC write,
// requests EXE bubbles, and tracks stall statistics with a sticky watchdog.
module stall_bubble_controller #(
    parameter int INSTR_WIDTH      = 32,
    parameter int PC_WIDTH         = 32,
    parameter int CNT_WIDTH        = 16,
    parameter int MAX_CONSEC_STALL = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic                   stall_pipeline_i,
    input  logic                   flush_i,
    input  logic                   fetch_valid_i,
    input  logic [INSTR_WIDTH-1:0] instr_FETCH_i,
    input  logic [PC_WIDTH-1:0]    pc_FETCH_i,
    output logic                   pc_write_en_o,
    output logic [INSTR_WIDTH-1:0] instr_DECODE_o,
    output logic [PC_WIDTH-1:0]    pc_DECODE_o,
    output logic                   valid_DECODE_o,
    output logic                   bubble_EXE_o,
    output logic                   stall_active_o,
    output logic [CNT_WIDTH-1:0]   stall_count_o,
    output logic                   stall_error_o
);

    localparam logic STALL_PIPELINE = 1'b1;
    localparam int CONSEC_W = $clog2(MAX_CONSEC_STALL + 1);
    localparam logic [CONSEC_W-1:0] CONSEC_MAX = CONSEC_W'(MAX_CONSEC_STALL);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } state_t;

    state_t              state;
    logic [CONSEC_W-1:0] consec_cnt;
    logic                stall;

    // A flush kills any concurrent stall request.
    assign stall          = (stall_pipeline_i == STALL_PIPELINE) && !flush_i;
    assign pc_write_en_o  = !stall;
    assign bubble_EXE_o   = stall || flush_i;
    assign stall_active_o = (state == STALL);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state          <= RUN;
            instr_DECODE_o <= '0;
            pc_DECODE_o    <= '0;
            valid_DECODE_o <= 1'b0;
            consec_cnt     <= '0;
            stall_count_o  <= '0;
            stall_error_o  <= 1'b0;
        end else begin
            case (state)
                RUN:     if (stall)  state <= STALL;
                STALL:   if (!stall) state <= RUN;
                default: state <= RUN;
            endcase

            if (flush_i) begin
                valid_DECODE_o <= 1'b0;
            end else if (!stall) begin
                instr_DECODE_o <= instr_FETCH_i;
                pc_DECODE_o    <= pc_FETCH_i;
                valid_DECODE_o <= fetch_valid_i;
            end

            // Watchdog trips on the edge where the run length reaches the limit.
            if (stall) begin
                if (consec_cnt != CONSEC_MAX) consec_cnt <= consec_cnt + 1'b1;
                if (consec_cnt >= CONSEC_MAX - 1'b1) stall_error_o <= 1'b1;
                if (stall_count_o != CNT_MAX) stall_count_o <= stall_count_o + 1'b1;
            end else begin
                consec_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_stall_bubble_controller.sv
// Self-checking bench for stall_bubble_controller: directed scenarios then random traffic,
// compared against a run-length based behavioural model.
module tb_stall_bubble_controller;

    localparam int IW = 32;
    localparam int PW = 32;
    localparam int CW = 3;
    localparam int MAXC = 4;
    localparam int CNT_SAT = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          stall_pipeline;
    logic          flush;
    logic          fetch_valid;
    logic [IW-1:0] instr_fetch;
    logic [PW-1:0] pc_fetch;
    logic          pc_write_en;
    logic [IW-1:0] instr_decode;
    logic [PW-1:0] pc_decode;
    logic          valid_decode;
    logic          bubble_exe;
    logic          stall_active;
    logic [CW-1:0] stall_count;
    logic          stall_error;

    int checks = 0;
    int errors = 0;

    // Model state, expressed as history facts rather than FSM registers
    logic [IW-1:0] m_instr;
    logic [PW-1:0] m_pc;
    logic          m_valid;
    logic          m_prev_stall;
    int            m_run;
    int            m_total;
    logic          m_err;

    stall_bubble_controller #(
        .INSTR_WIDTH(IW), .PC_WIDTH(PW), .CNT_WIDTH(CW), .MAX_CONSEC_STALL(MAXC)
    ) dut (
        .clk_i           (clk),
        .rst_n_i         (rst_n),
        .stall_pipeline_i(stall_pipeline),
        .flush_i         (flush),
        .fetch_valid_i   (fetch_valid),
        .instr_FETCH_i   (instr_fetch),
        .pc_FETCH_i      (pc_fetch),
        .pc_write_en_o   (pc_write_en),
        .instr_DECODE_o  (instr_decode),
        .pc_DECODE_o     (pc_decode),
        .valid_DECODE_o  (valid_decode),
        .bubble_EXE_o    (bubble_exe),
        .stall_active_o  (stall_active),
        .stall_count_o   (stall_count),
        .stall_error_o   (stall_error)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_instr      = '0;
        m_pc         = '0;
        m_valid      = 1'b0;
        m_prev_stall = 1'b0;
        m_run        = 0;
        m_total      = 0;
        m_err        = 1'b0;
    endtask

    task automatic check_regs(input string ctx);
        check({ctx, ".valid"}, 32'(valid_decode), 32'(m_valid));
        if (m_valid) begin
            check({ctx, ".instr"}, instr_decode, m_instr);
            check({ctx, ".pc"}, pc_decode, m_pc);
        end
        check({ctx, ".active"}, 32'(stall_active), 32'(m_prev_stall));
        check({ctx, ".count"}, 32'(stall_count), (m_total > CNT_SAT) ? CNT_SAT : m_total);
        check({ctx, ".err"}, 32'(stall_error), 32'(m_err));
    endtask

    // One clock cycle: verify registered state, apply inputs, verify combinational
    // outputs, then advance the model across the coming rising edge.
    task automatic cycle(input logic st, input logic fl, input logic fv,
                         input logic [IW-1:0] ins, input logic [PW-1:0] pc);
        logic s;
        @(negedge clk);
        check_regs("reg");
        stall_pipeline = st;
        flush          = fl;
        fetch_valid    = fv;
        instr_fetch    = ins;
        pc_fetch       = pc;
        s = st && !fl;
        #1;
        check("pc_we", 32'(pc_write_en), 32'(!s));
        check("bubble", 32'(bubble_exe), 32'(st || fl));
        if (fl) begin
            m_valid = 1'b0;
        end else if (!s) begin
            m_instr = ins;
            m_pc    = pc;
            m_valid = fv;
        end
        m_prev_stall = s;
        if (s) begin
            m_run++;
            m_total++;
            if (m_run >= MAXC) m_err = 1'b1;
        end else begin
            m_run = 0;
        end
    endtask

    function automatic logic [IW-1:0] op_of(input logic [PW-1:0] pc);
        return 32'hA500_0000 ^ pc;
    endfunction

    initial begin
        rst_n          = 1'b0;
        stall_pipeline = 1'b0;
        flush          = 1'b0;
        fetch_valid    = 1'b0;
        instr_fetch    = '0;
        pc_fetch       = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;

        // Plain fetch stream
        cycle(0, 0, 1, op_of(32'h0), 32'h0);
        cycle(0, 0, 1, op_of(32'h4), 32'h4);
        // Single stall with 0x4 in DECODE, then the held fetch loads 0x8
        cycle(1, 0, 1, op_of(32'h8), 32'h8);
        cycle(0, 0, 1, op_of(32'h8), 32'h8);
        // Flush with 0x8 valid in DECODE
        cycle(1'b0, 1, 1, op_of(32'hC), 32'hC);
        cycle(0, 0, 1, op_of(32'hC), 32'hC);
        // Stall and flush together behave as flush
        cycle(1, 1, 1, op_of(32'h10), 32'h10);
        cycle(0, 0, 1, op_of(32'h10), 32'h10);
        // Three-cycle stall stays below the watchdog limit
        repeat (3) cycle(1, 0, 0, 32'hDEAD, 32'hBEEF);
        cycle(0, 0, 1, op_of(32'h14), 32'h14);
        // Four consecutive stalls trip the watchdog; it stays set afterwards
        repeat (4) cycle(1, 0, 1, op_of(32'h18), 32'h18);
        cycle(0, 0, 1, op_of(32'h18), 32'h18);
        cycle(0, 0, 1, op_of(32'h1C), 32'h1C);
        // Long stall saturates the total counter
        repeat (10) cycle(1, 0, 1, op_of(32'h20), 32'h20);

        // Asynchronous reset mid-stall, asserted and released between edges
        @(negedge clk);
        check_regs("pre_rst");
        stall_pipeline = 1'b0;
        #1 rst_n = 1'b0;
        model_reset();
        #1;
        check_regs("async_rst");
        check("rst.pc_we", 32'(pc_write_en), 32'd1);
        check("rst.bubble", 32'(bubble_exe), 32'd0);
        @(posedge clk);
        #2 rst_n = 1'b1;

        // Random traffic with bursty stalls
        for (int i = 0; i < 400; i++) begin
            logic st, fl;
            logic [PW-1:0] pc;
            st = ($urandom_range(0, 99) < ((i % 80) < 40 ? 30 : 85));
            fl = ($urandom_range(0, 99) < 10);
            pc = $urandom() & 32'hFFFF_FFFC;
            cycle(st, fl, 1'($urandom_range(0, 1)), $urandom(), pc);
        end
        @(negedge clk);
        check_regs("final");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
